// File: rtl/lcd_hd44780_rx.sv
// Responder end of the HD44780 4-bit write interface: init tracking, command decode,
// address counter and 2xCOLS character buffer. Define LCD_RX_SYNC_EN for an async driver.
module lcd_hd44780_rx #(
   parameter int          COLS       = 16,
   parameter logic [7:0]  BLANK_CHAR = 8'h20
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          lcd_en,
   input  logic                          lcd_rs,
   input  logic [3:0]                    lcd_data,
   input  logic [$clog2(2*COLS)-1:0]     rd_addr,
   output logic [7:0]                    rd_data,
   output logic                          cmd_valid,
   output logic [7:0]                    cmd_byte,
   output logic                          data_valid,
   output logic [6:0]                    ac,
   output logic                          four_bit,
   output logic                          display_on,
   output logic                          busy,
   output logic                          err
);

   localparam int DEPTH = 2 * COLS;
   localparam int AW    = $clog2(DEPTH);

   typedef enum logic {PH_HI, PH_LO} phase_t;

   logic          en_in, rs_in;
   logic [3:0]    data_in;

`ifdef LCD_RX_SYNC_EN
   logic [1:0]    en_sync, rs_sync;
   logic [3:0]    data_s1, data_s2;

   always_ff @(posedge clk) begin
      if (reset) begin
         en_sync <= '0;
         rs_sync <= '0;
         data_s1 <= '0;
         data_s2 <= '0;
      end else begin
         en_sync <= {en_sync[0], lcd_en};
         rs_sync <= {rs_sync[0], lcd_rs};
         data_s1 <= lcd_data;
         data_s2 <= data_s1;
      end
   end

   assign en_in   = en_sync[1];
   assign rs_in   = rs_sync[1];
   assign data_in = data_s2;
`else
   assign en_in   = lcd_en;
   assign rs_in   = lcd_rs;
   assign data_in = lcd_data;
`endif

   logic          en_q, rs_q;
   logic [3:0]    data_q;
   logic          strobe, accept;

   always_ff @(posedge clk) begin
      if (reset) begin
         en_q   <= 1'b0;
         rs_q   <= 1'b0;
         data_q <= '0;
      end else begin
         en_q   <= en_in;
         rs_q   <= rs_in;
         data_q <= data_in;
      end
   end

   // Falling edge of en consumes the rs/data that were registered while en was high.
   assign strobe = en_q & ~en_in;
   assign accept = strobe & ~busy;

   phase_t        phase_q, phase_d;
   logic [3:0]    hi_nib;
   logic          hi_rs;
   logic          byte_done, byte_bad;
   logic [7:0]    byte_val;

   always_ff @(posedge clk) begin
      if (reset) phase_q <= PH_HI;
      else       phase_q <= phase_d;
   end

   always_comb begin
      phase_d   = phase_q;
      byte_done = 1'b0;
      byte_bad  = 1'b0;
      byte_val  = {data_q, 4'h0};
      if (accept) begin
         if (!four_bit) begin
            byte_done = 1'b1;
         end else if (phase_q == PH_HI) begin
            phase_d = PH_LO;
         end else begin
            phase_d  = PH_HI;
            byte_val = {hi_nib, data_q};
            if (rs_q != hi_rs) byte_bad  = 1'b1;
            else               byte_done = 1'b1;
         end
         if (byte_done && !rs_q && byte_val[7:5] == 3'b001) phase_d = PH_HI;
      end
   end

   logic [6:0]    ac_step;
   logic          increment;

   always_comb begin
      ac_step = ac;
      if (increment) begin
         if (ac == 7'h27)      ac_step = 7'h40;
         else if (ac == 7'h67) ac_step = 7'h00;
         else                  ac_step = ac + 7'd1;
      end else begin
         if (ac == 7'h00)      ac_step = 7'h67;
         else if (ac == 7'h40) ac_step = 7'h27;
         else                  ac_step = ac - 7'd1;
      end
   end

   logic [AW-1:0] clr_idx;
   logic          wr_en;
   logic [AW-1:0] wr_idx;
   logic [7:0]    wr_dat;

   // Clear and data writes share the single write port; strobes are refused while busy.
   always_comb begin
      wr_en  = 1'b0;
      wr_idx = clr_idx;
      wr_dat = BLANK_CHAR;
      if (!reset) begin
         if (busy) begin
            wr_en = 1'b1;
         end else if (byte_done && rs_q) begin
            wr_dat = byte_val;
            if (int'(ac) < COLS) begin
               wr_en  = 1'b1;
               wr_idx = AW'(ac);
            end else if (ac >= 7'h40 && int'(ac) < 'h40 + COLS) begin
               wr_en  = 1'b1;
               wr_idx = AW'(int'(ac) - 'h40 + COLS);
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cmd_valid  <= 1'b0;
         cmd_byte   <= '0;
         data_valid <= 1'b0;
         ac         <= '0;
         four_bit   <= 1'b0;
         display_on <= 1'b0;
         err        <= 1'b0;
         increment  <= 1'b1;
         busy       <= 1'b1;
         clr_idx    <= '0;
         hi_nib     <= '0;
         hi_rs      <= 1'b0;
      end else begin
         cmd_valid  <= 1'b0;
         data_valid <= 1'b0;
         if ((strobe && busy) || byte_bad) err <= 1'b1;
         if (accept && four_bit && phase_q == PH_HI) begin
            hi_nib <= data_q;
            hi_rs  <= rs_q;
         end
         if (busy) begin
            clr_idx <= clr_idx + AW'(1);
            if (clr_idx == AW'(DEPTH - 1)) busy <= 1'b0;
         end
         if (byte_done) begin
            if (rs_q) begin
               data_valid <= 1'b1;
               ac         <= ac_step;
            end else begin
               cmd_valid <= 1'b1;
               cmd_byte  <= byte_val;
               casez (byte_val)
                  8'b1???????: ac <= byte_val[6:0];
                  8'b01??????: ;
                  8'b001?????: four_bit <= ~byte_val[4];
                  8'b0001????: ;
                  8'b00001???: display_on <= byte_val[2];
                  8'b000001??: increment <= byte_val[1];
                  8'b0000001?: ac <= '0;
                  8'b00000001: begin
                     ac        <= '0;
                     increment <= 1'b1;
                     busy      <= 1'b1;
                     clr_idx   <= '0;
                  end
                  default: ;
               endcase
            end
         end
      end
   end

   logic [7:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_idx] <= wr_dat;
   end

   // Read-before-write: a same-edge write to rd_addr shows up one cycle later.
   always_ff @(posedge clk) begin
      if (reset) rd_data <= '0;
      else       rd_data <= mem[rd_addr];
   end

endmodule

// File: tb/tb_lcd_hd44780_rx.sv
// Bench for lcd_hd44780_rx: directed init/AC/error scenarios then random strobes,
// all outputs checked every cycle against a behavioural display model.
module tb_lcd_hd44780_rx;

   localparam int         COLS  = 16;
   localparam int         DEPTH = 2 * COLS;
   localparam int         AW    = $clog2(DEPTH);
   localparam logic [7:0] BLANK = 8'h20;

   logic          clk = 1'b0;
   logic          reset, lcd_en, lcd_rs;
   logic [3:0]    lcd_data;
   logic [AW-1:0] rd_addr;
   logic [7:0]    rd_data, cmd_byte;
   logic          cmd_valid, data_valid, four_bit, display_on, busy, err;
   logic [6:0]    ac;

   always #5 clk = ~clk;

   lcd_hd44780_rx #(.COLS(COLS), .BLANK_CHAR(BLANK)) dut (
      .clk(clk), .reset(reset), .lcd_en(lcd_en), .lcd_rs(lcd_rs), .lcd_data(lcd_data),
      .rd_addr(rd_addr), .rd_data(rd_data), .cmd_valid(cmd_valid), .cmd_byte(cmd_byte),
      .data_valid(data_valid), .ac(ac), .four_bit(four_bit), .display_on(display_on),
      .busy(busy), .err(err)
   );

   int n_vec  = 0;
   int n_fail = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   // ---------------- behavioural model ----------------
   logic [7:0] mbuf [DEPTH];
   bit         mknown [DEPTH];
   logic [7:0] m_rd, m_cmd_byte;
   logic       m_rd_known, m_cmd_valid, m_data_valid, m_four, m_disp, m_busy, m_err, m_inc;
   logic       m_phase_lo, m_hi_rs;
   logic [3:0] m_hi;
   logic [6:0] m_ac;
   int         m_clr_left;
   logic       m_en_prev, m_rs_prev;
   logic [3:0] m_d_prev;
   logic       p1_en, p2_en, p1_rs, p2_rs;
   logic [3:0] p1_d, p2_d;

   function automatic int buf_index(input logic [6:0] a);
      if (int'(a) < COLS) return int'(a);
      if (int'(a) >= 'h40 && int'(a) < 'h40 + COLS) return COLS + int'(a) - 'h40;
      return -1;
   endfunction

   function automatic logic [6:0] ac_after(input logic [6:0] a, input logic up);
      if (up) begin
         if (a == 7'h27) return 7'h40;
         if (a == 7'h67) return 7'h00;
         return a + 7'd1;
      end
      if (a == 7'h00) return 7'h67;
      if (a == 7'h40) return 7'h27;
      return a - 7'd1;
   endfunction

   task automatic model_byte(input logic rs, input logic [7:0] b);
      int idx;
      if (rs) begin
         m_data_valid = 1'b1;
         idx = buf_index(m_ac);
         if (idx >= 0) begin
            mbuf[idx]   = b;
            mknown[idx] = 1'b1;
         end
         m_ac = ac_after(m_ac, m_inc);
      end else begin
         m_cmd_valid = 1'b1;
         m_cmd_byte  = b;
         if (b[7])      m_ac = b[6:0];
         else if (b[6]) begin end
         else if (b[5]) begin m_four = ~b[4]; m_phase_lo = 1'b0; end
         else if (b[4]) begin end
         else if (b[3]) m_disp = b[2];
         else if (b[2]) m_inc = b[1];
         else if (b[1]) m_ac = 7'h00;
         else if (b[0]) begin
            m_ac = 7'h00; m_inc = 1'b1; m_busy = 1'b1; m_clr_left = DEPTH;
         end
      end
   endtask

   task automatic model_nibble(input logic rs, input logic [3:0] d);
      if (!m_four) begin
         model_byte(rs, {d, 4'h0});
      end else if (!m_phase_lo) begin
         m_hi = d; m_hi_rs = rs; m_phase_lo = 1'b1;
      end else begin
         m_phase_lo = 1'b0;
         if (rs != m_hi_rs) m_err = 1'b1;
         else               model_byte(rs, {m_hi, d});
      end
   endtask

   task automatic model_step(input logic r, input logic en_s, input logic rs_s,
                             input logic [3:0] d_s, input logic [AW-1:0] addr);
      logic e, rs;
      logic [3:0] d;
      logic old_busy;
      if (r) begin
         m_rd = 8'h00; m_rd_known = 1'b1; m_cmd_valid = 1'b0; m_data_valid = 1'b0;
         m_cmd_byte = 8'h00; m_ac = 7'h00; m_four = 1'b0; m_disp = 1'b0; m_err = 1'b0;
         m_inc = 1'b1; m_phase_lo = 1'b0; m_busy = 1'b1; m_clr_left = DEPTH;
         m_hi = 4'h0; m_hi_rs = 1'b0;
         m_en_prev = 1'b0; m_rs_prev = 1'b0; m_d_prev = 4'h0;
         p1_en = 1'b0; p2_en = 1'b0; p1_rs = 1'b0; p2_rs = 1'b0; p1_d = 4'h0; p2_d = 4'h0;
         return;
      end
`ifdef LCD_RX_SYNC_EN
      e = p2_en; rs = p2_rs; d = p2_d;
      p2_en = p1_en; p2_rs = p1_rs; p2_d = p1_d;
      p1_en = en_s;  p1_rs = rs_s;  p1_d = d_s;
`else
      e = en_s; rs = rs_s; d = d_s;
`endif
      m_rd         = mbuf[addr];
      m_rd_known   = mknown[addr];
      m_cmd_valid  = 1'b0;
      m_data_valid = 1'b0;
      old_busy     = m_busy;
      if (m_en_prev && !e) begin
         if (old_busy) m_err = 1'b1;
         else          model_nibble(m_rs_prev, m_d_prev);
      end
      if (old_busy) begin
         mbuf[DEPTH - m_clr_left]   = BLANK;
         mknown[DEPTH - m_clr_left] = 1'b1;
         m_clr_left--;
         if (m_clr_left == 0) m_busy = 1'b0;
      end
      m_en_prev = e; m_rs_prev = rs; m_d_prev = d;
   endtask

   // ---------------- compare process ----------------
   int         dv_count = 0;
   logic [7:0] dut_cmd_q [$];

   initial begin
      logic          c_reset, c_en, c_rs;
      logic [3:0]    c_d;
      logic [AW-1:0] c_addr;
      forever begin
         @(posedge clk);
         c_reset = reset; c_en = lcd_en; c_rs = lcd_rs; c_d = lcd_data; c_addr = rd_addr;
         @(negedge clk);
         model_step(c_reset, c_en, c_rs, c_d, c_addr);
         if (m_rd_known) chk("rd_data", 32'(rd_data), 32'(m_rd));
         chk("cmd_valid",  32'(cmd_valid),  32'(m_cmd_valid));
         chk("cmd_byte",   32'(cmd_byte),   32'(m_cmd_byte));
         chk("data_valid", 32'(data_valid), 32'(m_data_valid));
         chk("ac",         32'(ac),         32'(m_ac));
         chk("four_bit",   32'(four_bit),   32'(m_four));
         chk("display_on", 32'(display_on), 32'(m_disp));
         chk("busy",       32'(busy),       32'(m_busy));
         chk("err",        32'(err),        32'(m_err));
         if (cmd_valid === 1'b1)  dut_cmd_q.push_back(cmd_byte);
         if (data_valid === 1'b1) dv_count++;
      end
   end

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(negedge clk);
      rd_addr = AW'($urandom_range(0, DEPTH - 1));
   endtask

   task automatic settle();
      repeat (3) tick();
   endtask

   task automatic strobe(input logic rs, input logic [3:0] nib, input int hold = 1, input int gap = 1);
      lcd_en = 1'b1; lcd_rs = rs; lcd_data = nib;
      repeat (hold) tick();
      lcd_en = 1'b0; lcd_rs = 1'($urandom); lcd_data = 4'($urandom);
      repeat (gap) tick();
   endtask

   task automatic send_byte(input logic rs, input logic [7:0] b, input logic four);
      strobe(rs, b[7:4]);
      if (four) strobe(rs, b[3:0]);
   endtask

   task automatic pulse_reset();
      reset = 1'b1;
      tick(); tick();
      reset = 1'b0;
   endtask

   task automatic busy_len(input string name);
      int w = 0;
      int n = 0;
      while (busy !== 1'b1 && w < 8) begin tick(); w++; end
      while (busy === 1'b1 && n < 100) begin n++; tick(); end
      chk(name, 32'(n), 32'(DEPTH));
   endtask

   task automatic read_check(input int a, input logic [7:0] exp);
      @(negedge clk);
      rd_addr = AW'(a);
      @(negedge clk);
      chk("rd_lit", 32'(rd_data), 32'(exp));
   endtask

   task automatic init4();
      strobe(0, 4'h3); strobe(0, 4'h3); strobe(0, 4'h3); strobe(0, 4'h2);
      settle();
   endtask

   initial begin
      #1000000;
      $display("FAIL timeout: bench did not finish");
      $fatal(1);
   end

   // ---------------- directed + random sequence ----------------
   initial begin
      logic [7:0] init_seq [8];
      int dv0, nq0;
      init_seq = '{8'h30, 8'h30, 8'h30, 8'h20, 8'h28, 8'h0C, 8'h06, 8'h01};
      reset = 1'b1; lcd_en = 1'b0; lcd_rs = 1'b0; lcd_data = 4'h0; rd_addr = '0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      busy_len("busy_after_reset");
      chk("ac_reset", 32'(ac), 32'h0);
      chk("four_bit_reset", 32'(four_bit), 32'h0);
      for (int i = 0; i < DEPTH; i++) read_check(i, BLANK);

      dut_cmd_q.delete();
      init4();
      chk("four_bit_init", 32'(four_bit), 32'h1);
      send_byte(0, 8'h28, 1); send_byte(0, 8'h0C, 1); send_byte(0, 8'h06, 1); send_byte(0, 8'h01, 1);
      busy_len("busy_clear");
      chk("display_on_init", 32'(display_on), 32'h1);
      chk("cmd_seq_len", 32'(dut_cmd_q.size()), 32'd8);
      for (int i = 0; i < 8; i++)
         chk("cmd_seq", (i < dut_cmd_q.size()) ? 32'(dut_cmd_q[i]) : 32'hFFFF, 32'(init_seq[i]));

      dv0 = dv_count;
      send_byte(0, 8'hC4, 1); send_byte(1, 8'h31, 1); send_byte(1, 8'h32, 1);
      settle();
      chk("ac_row1", 32'(ac), 32'h46);
      chk("dv_pulses", 32'(dv_count - dv0), 32'd2);
      read_check(20, 8'h31);
      read_check(21, 8'h32);

      send_byte(0, 8'h04, 1); send_byte(0, 8'h80, 1); send_byte(1, 8'h41, 1);
      settle();
      chk("ac_dec_wrap", 32'(ac), 32'h67);
      read_check(0, 8'h41);
      send_byte(1, 8'h42, 1);
      settle();
      chk("ac_dropped", 32'(ac), 32'h66);
      read_check(DEPTH - 1, BLANK);

      dv0 = dv_count; nq0 = dut_cmd_q.size();
      strobe(0, 4'h4); strobe(1, 4'h1);
      settle();
      chk("err_rs_mismatch", 32'(err), 32'h1);
      chk("mismatch_no_data", 32'(dv_count - dv0), 32'd0);
      chk("mismatch_no_cmd", 32'(dut_cmd_q.size() - nq0), 32'd0);
      send_byte(0, 8'h0C, 1);
      settle();
      chk("phase_after_mismatch", 32'(cmd_byte), 32'h0C);

      send_byte(0, 8'h01, 1);
      repeat (10) tick();
      pulse_reset();
      busy_len("busy_reset_mid_clear");
      chk("four_bit_after_reset", 32'(four_bit), 32'h0);
      chk("err_after_reset", 32'(err), 32'h0);

      strobe(0, 4'h2);
      settle();
      strobe(1, 4'h4);
      pulse_reset();
      busy_len("busy_reset_mid_byte");
      chk("four_bit_mid_byte", 32'(four_bit), 32'h0);
      strobe(0, 4'h2);
      settle();
      send_byte(0, 8'h0C, 1);
      settle();
      chk("phase_after_reset", 32'(cmd_byte), 32'h0C);

      send_byte(0, 8'h01, 1);
      strobe(1, 4'h5);
      settle();
      chk("err_busy_strobe", 32'(err), 32'h1);
      repeat (40) tick();
      send_byte(0, 8'h06, 1);
      settle();
      chk("phase_after_busy_drop", 32'(cmd_byte), 32'h06);

      pulse_reset();
      repeat (DEPTH + 2) tick();
      init4();
      for (int k = 0; k < 400; k++) begin
         int r;
         r = $urandom_range(0, 99);
         if (r < 2) pulse_reset();
         else if (r < 8) repeat ($urandom_range(1, 40)) tick();
         else strobe(1'($urandom_range(0, 5) != 0), 4'($urandom), $urandom_range(1, 3), $urandom_range(1, 2));
      end
      repeat (40) tick();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule

// File: doc/lcd_hd44780_rx.md
Name: lcd_hd44780_rx

Overview:
- Responder end of the HD44780 4-bit LCD write interface: a behavioural-grade controller that receives en/rs/data nibble strobes from the LCD driver.
- Tracks the 8-bit/4-bit init handshake, decodes commands, maintains the address counter (AC) and stores characters into a 2x COLS display buffer.
- Buffer contents are readable by the bench or by an on-chip echo/readback path.
- Sits on the same clk as the driver; used for loopback checking of the driver on silicon and in simulation.

Parameters:
- COLS, 16, visible columns per row; buffer holds 2*COLS bytes.
- BLANK_CHAR, 8'h20, fill value written by clear.

Ports:
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- lcd_en  in  1  enable strobe from driver; write is consumed on its falling edge
- lcd_rs  in  1  0 = command, 1 = data
- lcd_data  in  4  nibble (in 8-bit mode, the upper data bits)
- rd_addr  in  $clog2(2*COLS)  buffer read index; row0 = 0..COLS-1, row1 = COLS..2*COLS-1
- rd_data  out  8  registered buffer byte at rd_addr
- cmd_valid  out  1  one-cycle pulse: command byte completed
- cmd_byte  out  8  last completed command byte
- data_valid  out  1  one-cycle pulse: data byte completed
- ac  out  7  address counter
- four_bit  out  1  interface currently in 4-bit mode
- display_on  out  1  display-control D bit
- busy  out  1  clear in progress
- err  out  1  sticky protocol error

Behaviour:
- Input stage: en_q, rs_q, data_q are registered copies of the inputs. A strobe occurs at a clk edge where en_q=1 and lcd_en=0. The consumed values are rs_q/data_q, i.e. those held while en was high. All strobe effects are registered at that same edge.
- Reset values: rd_data=0, cmd_valid=0, data_valid=0, cmd_byte=0, ac=0, four_bit=0, display_on=0, err=0, increment=1, nibble phase=HI, busy=1, clear index=0.
- After reset deasserts, an automatic clear runs: BLANK_CHAR is written to one location per cycle for 2*COLS cycles, then busy drops. Reset mid-clear restarts the clear from index 0.
- Byte assembly:
  - 8-bit mode: every strobe yields byte {data_q, 4'h0}.
  - 4-bit mode: phase HI stores the high nibble and rs; phase LO completes the byte as {hi, data_q}.
  - If rs differs between HI and LO: byte discarded, err=1, phase returns to HI.
- Command decode (rs=0), first matching bit from MSB:
  - b7: AC = b[6:0].
  - b6: CGRAM address; ignored.
  - b5: function set; four_bit = ~b4. Phase is forced to HI.
  - b4: shift; ignored.
  - b3: display_on = b2.
  - b2: increment = b1.
  - b1: AC = 0.
  - b0: AC = 0, increment = 1, start clear (busy = 1 for 2*COLS cycles).
  - cmd_valid pulses and cmd_byte updates for every command, including ignored ones.
- Data write (rs=1):
  - If AC is in 0x00..COLS-1, write buffer[AC]; if AC is in 0x40..0x40+COLS-1, write buffer[COLS + AC - 0x40]; otherwise the byte is dropped.
  - AC then steps by ±1 per increment.
  - Increment wrap: 0x27→0x40 and 0x67→0x00. Decrement wrap: 0x00→0x67 and 0x40→0x27.
  - data_valid pulses.
- Busy: a strobe while busy=1 is dropped (no state change, no phase advance) and sets err=1. err clears only on reset.
- Read port: rd_data = buffer[rd_addr], registered, 1-cycle latency. If a write and a read hit the same index on the same edge, rd_data returns the old value.
- Idle en high: no action until the falling edge. Back-to-back strobes every 2 cycles are supported.

Optional Feature:
- LCD_RX_SYNC_EN:
  - Defined: lcd_en, lcd_rs and lcd_data pass through a 2-flop synchronizer before the input stage, for an asynchronous driver. Strobe latency grows by 2 cycles; capture still uses values held while en was high.
  - Undefined: single register stage as above.

Test Plan:
- Reset, then 2*COLS+1 idle cycles → busy falls after exactly 2*COLS cycles; all rd_addr 0..31 read 8'h20; ac=0, four_bit=0.
- Driver init: nibbles 3,3,3,2 then bytes 0x28, 0x0C, 0x06, 0x01 → four_bit=1 after nibble 2. cmd_byte sequence is 0x30, 0x30, 0x30, 0x20, 0x28, 0x0C, 0x06, 0x01. display_on=1, busy high 32 cycles after 0x01.
- After init: command 0xC4, then data 0x31, 0x32 → buffer[20]=0x31, buffer[21]=0x32, ac=0x46, two data_valid pulses.
- Entry mode 0x04, AC set 0x80, data 0x41 → buffer[0]=0x41, ac=0x67. Then data 0x42 → dropped (ac 0x67 is outside both ranges), ac=0x66.
- Strobe during clear (within 32 cycles after 0x01) → ignored, err=1, nibble phase unchanged. rs=0 HI nibble followed by rs=1 LO nibble → err=1, no write, next nibble treated as HI.
- Assert reset mid-clear and mid-byte (after HI nibble) → phase HI, four_bit=0, clear restarts, busy lasts 32 cycles from deassertion.
